seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode seven-segment display. It holds a double-buffered display image: per-digit hex nibbles, decimal points and a digit-enable mask. It cycles through the digits with a programmable on-time and an all-off dead time to prevent ghosting. The code[3:0] it presents each slot feeds the existing hex-to-segment decoder, whose active-low seg output drives the cathodes. The host writes new images through a valid/ready handshake, and each image is committed only at a frame boundary so the display never tears.

---
 rtl/seg_scan_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for an N-digit common-anode seven-segment
// display. The host writes a display image (hex nibbles, decimal points and a
// digit-enable mask) into a shadow buffer through a valid/ready handshake. The
// image is copied to the active buffer only at a frame boundary, or while the
// scanner is parked, so a frame is never drawn from two different images.
// Each digit is driven for ON_CYCLES clocks, followed by GAP_CYCLES clocks with
// every anode off to suppress ghosting.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         scan enable; 0 blanks the display and parks the scanner
//   wr_valid   host image write request
//   wr_ready   shadow buffer free (write accepted on wr_valid & wr_ready)
//   wr_data    hex nibbles, digit i on wr_data[4i+3:4i]
//   wr_dp      decimal point per digit, 1 = lit
//   wr_mask    digit enable per digit, 0 = dark
//   an         anode selects, active-low
//   code       nibble of the current digit, to the hex-to-segment decoder
//   dp_n       decimal point, active-low
//   frame_done one-cycle pulse at the end of every completed frame
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int N_DIGITS   = 8,
  parameter int ON_CYCLES  = 100000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*N_DIGITS-1:0] wr_data,
  input  logic [N_DIGITS-1:0]   wr_dp,
  input  logic [N_DIGITS-1:0]   wr_mask,
  output logic [N_DIGITS-1:0]   an,
  output logic [3:0]            code,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CNT_MAX = ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ON  = 2'd1,
    ST_GAP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [3:0]            code_q, code_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_done_q, frame_done_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  pending_q, pending_d;

  logic [4*N_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [N_DIGITS-1:0]   shadow_mask_q, shadow_mask_d;
  logic [4*N_DIGITS-1:0] active_data_q, active_data_d;
  logic [N_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [N_DIGITS-1:0]   active_mask_q, active_mask_d;

  // Slot sequencing decisions, derived from current state only.
  logic             enter_on;
  logic             wrap;
  logic [IDX_W-1:0] next_idx;

  always_comb begin
    enter_on = 1'b0;
    wrap     = 1'b0;
    next_idx = '0;
    if (en) begin
      unique case (state_q)
        ST_OFF: enter_on = 1'b1;
        ST_ON:  enter_on = (cnt_q == ON_LAST) && !HAS_GAP;
        ST_GAP: enter_on = (cnt_q == GAP_LAST);
        default: enter_on = 1'b0;
      endcase
      // Leaving a slot (not starting from OFF) advances the digit; leaving
      // the last digit's slot is the frame wrap.
      if (enter_on && (state_q != ST_OFF)) begin
        if (idx_q == IDX_LAST) begin
          wrap = 1'b1;
        end else begin
          next_idx = idx_q + 1'b1;
        end
      end
    end
  end

  // Commit uses pending_q, so a write accepted on the wrap edge itself waits
  // for the following wrap.
  logic accept;
  logic commit;
  assign accept = wr_valid && wr_ready_q;
  assign commit = pending_q && (wrap || (state_q == ST_OFF));

  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_mask_d = shadow_mask_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    active_mask_d = active_mask_q;
    pending_d     = pending_q;
    wr_ready_d    = wr_ready_q;
    if (commit) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      active_mask_d = shadow_mask_q;
      pending_d     = 1'b0;
      wr_ready_d    = 1'b1;
    end
    if (accept) begin
      shadow_data_d = wr_data;
      shadow_dp_d   = wr_dp;
      shadow_mask_d = wr_mask;
      pending_d     = 1'b1;
      wr_ready_d    = 1'b0;
    end
  end

  // Per-digit nibbles of the image that will be active after this edge, so a
  // wrap commit is already visible in digit 0 of the new frame.
  logic [3:0] next_nibble [N_DIGITS];
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nibble
    assign next_nibble[gi] = active_data_d[4*gi +: 4];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    an_d         = an_q;
    code_d       = code_q;
    dp_n_d       = dp_n_q;
    frame_done_d = wrap;
    if (!en) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
      an_d    = '1;
    end else if (enter_on) begin
      state_d          = ST_ON;
      idx_d            = next_idx;
      cnt_d            = '0;
      an_d             = '1;
      an_d[next_idx]   = ~active_mask_d[next_idx];
      code_d           = next_nibble[next_idx];
      dp_n_d           = ~active_dp_d[next_idx];
    end else if ((state_q == ST_ON) && (cnt_q == ON_LAST)) begin
      // Only reached when a gap exists; code/dp_n hold through the gap.
      state_d = ST_GAP;
      cnt_d   = '0;
      an_d    = '1;
    end else if (state_q != ST_OFF) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_OFF;
      idx_q         <= '0;
      cnt_q         <= '0;
      an_q          <= '1;
      code_q        <= '0;
      dp_n_q        <= 1'b1;
      frame_done_q  <= 1'b0;
      wr_ready_q    <= 1'b1;
      pending_q     <= 1'b0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_mask_q <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      active_mask_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      an_q          <= an_d;
      code_q        <= code_d;
      dp_n_q        <= dp_n_d;
      frame_done_q  <= frame_done_d;
      wr_ready_q    <= wr_ready_d;
      pending_q     <= pending_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_mask_q <= shadow_mask_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      active_mask_q <= active_mask_d;
    end
  end

  assign an         = an_q;
  assign code       = code_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;
  assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Directed self-checking bench for seg_scan_ctrl with N_DIGITS=8, ON_CYCLES=4,
// GAP_CYCLES=2 (6-cycle slot, 48-cycle frame). Inputs change and outputs are
// sampled on the falling clock edge. In each scan loop, k=1 is the first
// sample after the edge that enters digit 0's ON slot, so digit index is
// ((k-1)/6)%8, the ON portion is (k-1)%6 < 4, and frame_done shows at k=49.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int N    = 8;
  localparam int SLOT = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_dp = '0;
  logic [7:0]  wr_mask = '0;
  logic [7:0]  an;
  logic [3:0]  code;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  seg_scan_ctrl #(
    .N_DIGITS  (8),
    .ON_CYCLES (4),
    .GAP_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .wr_mask   (wr_mask),
    .an        (an),
    .code      (code),
    .dp_n      (dp_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Anode pattern at sample k for a given mask.
  function automatic logic [7:0] exp_an(input int k, input logic [7:0] mask);
    int idx;
    int pos;
    idx = ((k - 1) / SLOT) % N;
    pos = (k - 1) % SLOT;
    if (pos < 4 && mask[idx]) return 8'hFF ^ (8'h01 << idx);
    return 8'hFF;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL reset_an got=%h exp=ff", an); end
    checks++; if (code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h exp=0", code); end
    checks++; if (dp_n !== 1'b1) begin failures++; $display("FAIL reset_dp_n got=%b exp=1", dp_n); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL post_reset_an got=%h exp=ff", an); end
    $display("test_reset done");
  endtask

  task automatic test_blank_scan();
    en = 1'b1;
    for (int k = 1; k <= 97; k++) begin
      @(negedge clk);
      checks++; if (an !== 8'hFF) begin failures++; $display("FAIL blank_an k=%0d got=%h exp=ff", k, an); end
      checks++; if (code !== 4'h0) begin failures++; $display("FAIL blank_code k=%0d got=%h exp=0", k, code); end
      checks++;
      if (frame_done !== ((k == 49) || (k == 97))) begin
        failures++; $display("FAIL blank_frame_done k=%0d got=%b exp=%b", k, frame_done, (k == 49) || (k == 97));
      end
    end
    en = 1'b0;
    $display("test_blank_scan done");
  endtask

  task automatic test_write_commit();
    int idx;
    @(negedge clk);
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL wc_off_an got=%h exp=ff", an); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL wc_ready_idle got=%b exp=1", wr_ready); end
    wr_valid = 1'b1; wr_data = 32'h76543210; wr_dp = 8'h01; wr_mask = 8'hFF;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL wc_ready_busy got=%b exp=0", wr_ready); end
    wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL wc_ready_commit got=%b exp=1", wr_ready); end
    en = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      @(negedge clk);
      idx = ((k - 1) / SLOT) % N;
      checks++; if (an !== exp_an(k, 8'hFF)) begin failures++; $display("FAIL wc_an k=%0d got=%h exp=%h", k, an, exp_an(k, 8'hFF)); end
      checks++; if (code !== 4'(idx)) begin failures++; $display("FAIL wc_code k=%0d got=%h exp=%h", k, code, 4'(idx)); end
      checks++; if (dp_n !== (idx != 0)) begin failures++; $display("FAIL wc_dp_n k=%0d got=%b exp=%b", k, dp_n, idx != 0); end
      checks++; if (frame_done !== (k == 49)) begin failures++; $display("FAIL wc_frame_done k=%0d got=%b exp=%b", k, frame_done, k == 49); end
    end
    $display("test_write_commit done");
  endtask

  task automatic test_midframe_write();
    int  idx;
    logic [3:0] ecode;
    logic edp;
    logic erdy;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      idx   = ((k - 1) / SLOT) % N;
      ecode = (k >= 49) ? 4'(8 + idx) : 4'(idx);
      edp   = (k >= 49) ? 1'b1 : (idx != 0);
      erdy  = (k <= 10) || (k >= 49);
      checks++; if (an !== exp_an(k, 8'hFF)) begin failures++; $display("FAIL mw_an k=%0d got=%h exp=%h", k, an, exp_an(k, 8'hFF)); end
      checks++; if (code !== ecode) begin failures++; $display("FAIL mw_code k=%0d got=%h exp=%h", k, code, ecode); end
      checks++; if (dp_n !== edp) begin failures++; $display("FAIL mw_dp_n k=%0d got=%b exp=%b", k, dp_n, edp); end
      checks++; if (wr_ready !== erdy) begin failures++; $display("FAIL mw_wr_ready k=%0d got=%b exp=%b", k, wr_ready, erdy); end
      if (k == 10) begin
        wr_valid = 1'b1; wr_data = 32'hFEDCBA98; wr_dp = 8'h00; wr_mask = 8'hFF;
      end
      if (k == 11) wr_valid = 1'b0;
    end
    $display("test_midframe_write done");
  endtask

  task automatic test_en_drop();
    int idx;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      idx = ((k - 1) / SLOT) % N;
      checks++; if (code !== 4'(8 + idx)) begin failures++; $display("FAIL ed_code k=%0d got=%h exp=%h", k, code, 4'(8 + idx)); end
      checks++; if (an !== exp_an(k, 8'hFF)) begin failures++; $display("FAIL ed_an k=%0d got=%h exp=%h", k, an, exp_an(k, 8'hFF)); end
    end
    en = 1'b0;
    for (int k = 21; k <= 55; k++) begin
      @(negedge clk);
      checks++; if (an !== 8'hFF) begin failures++; $display("FAIL ed_off_an k=%0d got=%h exp=ff", k, an); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL ed_off_frame_done k=%0d got=%b exp=0", k, frame_done); end
    end
    en = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      checks++; if (an !== exp_an(j, 8'hFF)) begin failures++; $display("FAIL ed_restart_an j=%0d got=%h exp=%h", j, an, exp_an(j, 8'hFF)); end
      checks++;
      if (code !== ((j == 7) ? 4'h9 : 4'h8)) begin
        failures++; $display("FAIL ed_restart_code j=%0d got=%h exp=%h", j, code, (j == 7) ? 4'h9 : 4'h8);
      end
    end
    $display("test_en_drop done");
  endtask

  task automatic test_mask();
    int idx;
    en = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 32'h76543210; wr_dp = 8'h00; wr_mask = 8'hAA;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL mk_ready_commit got=%b exp=1", wr_ready); end
    en = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      idx = ((k - 1) / SLOT) % N;
      checks++; if (an !== exp_an(k, 8'hAA)) begin failures++; $display("FAIL mk_an k=%0d got=%h exp=%h", k, an, exp_an(k, 8'hAA)); end
      checks++; if (code !== 4'(idx)) begin failures++; $display("FAIL mk_code k=%0d got=%h exp=%h", k, code, 4'(idx)); end
    end
    $display("test_mask done");
  endtask

  task automatic test_reset_mid();
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= 7; k++) @(negedge clk);
    // Sample 7 is the first cycle of digit 1's ON slot (lit under mask AA).
    wr_valid = 1'b1; wr_data = 32'h11111111; wr_dp = 8'hFF; wr_mask = 8'hFF;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rm_pending_ready got=%b exp=0", wr_ready); end
    checks++; if (an !== 8'hFD) begin failures++; $display("FAIL rm_pre_an got=%h exp=fd", an); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (an !== 8'hFF) begin failures++; $display("FAIL rm_async_an got=%h exp=ff", an); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rm_async_ready got=%b exp=1", wr_ready); end
    checks++; if (code !== 4'h0) begin failures++; $display("FAIL rm_async_code got=%h exp=0", code); end
    checks++; if (dp_n !== 1'b1) begin failures++; $display("FAIL rm_async_dp_n got=%b exp=1", dp_n); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      checks++; if (an !== 8'hFF) begin failures++; $display("FAIL rm_dark_an k=%0d got=%h exp=ff", k, an); end
      checks++; if (code !== 4'h0) begin failures++; $display("FAIL rm_dark_code k=%0d got=%h exp=0", k, code); end
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rm_dark_ready k=%0d got=%b exp=1", k, wr_ready); end
      checks++; if (frame_done !== (k == 49)) begin failures++; $display("FAIL rm_frame_done k=%0d got=%b exp=%b", k, frame_done, k == 49); end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_blank_scan();
    test_write_commit();
    test_midframe_write();
    test_en_drop();
    test_mask();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
